// File: rtl/div_q_pkg.sv
// div_q_pkg: shared constants and types for the divider job queue.
//   - seq_divider register offsets (the bus this block masters)
//   - host-side register offsets of div_job_queue
//   - STATUS bit positions
//   - engine FSM state encoding and the per-state divider bus drive
package div_q_pkg;

  // seq_divider register offsets
  localparam logic [7:0] DIV_INFO = 8'h00;
  localparam logic [7:0] DIV_END  = 8'h04;
  localparam logic [7:0] DIV_SOR  = 8'h08;
  localparam logic [7:0] DIV_QUO  = 8'h0C;
  localparam logic [7:0] DIV_REM  = 8'h10;

  // div_job_queue host register offsets
  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] REG_JOB_END = 8'h04;
  localparam logic [7:0] REG_JOB_SOR = 8'h08;
  localparam logic [7:0] REG_RES_QUO = 8'h0C;
  localparam logic [7:0] REG_RES_REM = 8'h10;
  localparam logic [7:0] REG_RES_POP = 8'h14;
  localparam logic [7:0] REG_CTRL    = 8'h18;

  // STATUS bit positions
  localparam int ST_ACTIVE      = 0;
  localparam int ST_JOB_FULL    = 1;
  localparam int ST_RES_VALID   = 2;
  localparam int ST_JOB_OVF     = 3;
  localparam int ST_TIMEOUT     = 4;
  localparam int ST_JOB_CNT_LSB = 8;
  localparam int ST_RES_CNT_LSB = 12;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_WR_END,
    S_WR_SOR,
    S_POLL,
    S_RD_QUO,
    S_RD_REM,
    S_PUSH
  } eng_state_t;

  typedef struct packed {
    logic [7:0]  address;
    logic [31:0] write_data;
    logic        we;
    logic        re;
  } div_bus_t;

  // Divider bus values to present while sitting in state st.
  // job_head is the job FIFO head: {dividend, divisor}.
  function automatic div_bus_t bus_for_state(input eng_state_t st, input logic [63:0] job_head);
    div_bus_t b;
    b.address    = DIV_INFO;
    b.write_data = '0;
    b.we         = 1'b0;
    b.re         = 1'b0;
    case (st)
      S_SYNC, S_POLL: b.re = 1'b1;
      S_WR_END: begin
        b.address    = DIV_END;
        b.write_data = job_head[63:32];
        b.we         = 1'b1;
      end
      S_WR_SOR: begin
        b.address    = DIV_SOR;
        b.write_data = job_head[31:0];
        b.we         = 1'b1;
      end
      S_RD_QUO: begin
        b.address = DIV_QUO;
        b.re      = 1'b1;
      end
      S_RD_REM: begin
        b.address = DIV_REM;
        b.re      = 1'b1;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/div_job_queue_if.sv
// div_job_queue_if: 8-bit-offset register bus shared by the host port and
// the seq_divider port.
//   address    : register offset        (master -> slave)
//   write_data : write data             (master -> slave)
//   we / re    : write / read strobes   (master -> slave)
//   read_data  : read data, combinational from address (slave -> master)
interface div_job_queue_if;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;

  modport master (
    output address,
    output write_data,
    output we,
    output re,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  we,
    input  re,
    output read_data
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head output.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din when not full (dropped when full or flushing)
//   pop      : discard head when not empty (ignored when empty or flushing)
//   flush    : empty the FIFO; wins over push/pop in the same cycle
//   head     : current head entry (stale data when empty)
//   full/empty/count : derived from the registered occupancy
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  // Full/empty come from the registered count, so a push while full is
  // dropped even if a pop happens in the same cycle.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/div_job_queue.sv
// div_job_queue: job/result queueing front end for seq_divider.
//   clk, rst : clock, synchronous active-high reset
//   host     : slave register bus (STATUS, JOB_END, JOB_SOR, RES_QUO,
//              RES_REM, RES_POP, CTRL); read_data is combinational
//   div      : master register bus driving seq_divider
// The host stages a dividend, then pushes {dividend, divisor} with a JOB_SOR
// write. The engine FSM feeds each job to the divider (END, SOR, poll INFO,
// read QUO, REM) and queues {quotient, remainder} in the result FIFO.
module div_job_queue #(
  parameter int DEPTH      = 4,
  parameter int POLL_LIMIT = 48
) (
  input  logic            clk,
  input  logic            rst,
  div_job_queue_if.slave  host,
  div_job_queue_if.master div
);
  import div_q_pkg::*;

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  // Host-side state
  logic [31:0] end_stage_reg;
  logic        job_ovf_reg;
  logic        timeout_reg;

  // Engine state
  eng_state_t     state_reg;
  logic [PCW-1:0] poll_cnt_reg;
  logic [31:0]    quo_reg;
  logic [31:0]    rem_reg;
  logic           discard_reg;
  div_bus_t       bus_reg;

  // FIFO views
  logic [63:0]   job_head, res_head;
  logic          job_full, job_empty, res_full, res_empty;
  logic [CW-1:0] job_count, res_count;

  // Host decode
  logic stage_wr, job_push, res_pop, ctrl_wr, flush_req, clr_flags;
  assign stage_wr  = host.we && (host.address == REG_JOB_END);
  assign job_push  = host.we && (host.address == REG_JOB_SOR);
  assign res_pop   = host.we && (host.address == REG_RES_POP);
  assign ctrl_wr   = host.we && (host.address == REG_CTRL);
  assign flush_req = ctrl_wr && host.write_data[1];
  assign clr_flags = ctrl_wr && host.write_data[0];

  // Engine events
  logic busy, job_pop, res_push, timeout_hit, in_job;
  assign busy        = div.read_data[0];
  assign job_pop     = (state_reg == S_WR_SOR);
  assign res_push    = (state_reg == S_PUSH) && !discard_reg && !res_full;
  assign timeout_hit = (state_reg == S_POLL) && busy && (poll_cnt_reg == POLL_LAST);
  assign in_job      = (state_reg != S_SYNC) && (state_reg != S_IDLE);

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_push),
    .pop   (job_pop),
    .flush (flush_req),
    .din   ({end_stage_reg, host.write_data}),
    .head  (job_head),
    .full  (job_full),
    .empty (job_empty),
    .count (job_count)
  );

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .pop   (res_pop),
    .flush (flush_req),
    .din   ({quo_reg, rem_reg}),
    .head  (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  // Staged dividend and sticky flags. A set in the same cycle as a clear
  // wins, so an event is never lost to a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      end_stage_reg <= '0;
      job_ovf_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      if (stage_wr) end_stage_reg <= host.write_data;
      job_ovf_reg <= (job_ovf_reg && !clr_flags) || (job_push && job_full);
      timeout_reg <= (timeout_reg && !clr_flags) || timeout_hit;
    end
  end

  // Engine FSM. Divider bus outputs are registered: every transition loads
  // the bus value belonging to the state being entered. With WR_END at
  // cycle w, POLL starts at w+2 and the result FIFO is written at the end
  // of PUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_SYNC;
      poll_cnt_reg <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      discard_reg  <= 1'b0;
      bus_reg      <= bus_for_state(S_SYNC, '0);
    end else begin
      case (state_reg)
        S_SYNC: begin
          // The divider may still be busy with a job we abandoned.
          if (!busy) begin
            state_reg <= S_IDLE;
            bus_reg   <= bus_for_state(S_IDLE, job_head);
          end
        end
        S_IDLE: begin
          if (!job_empty) begin
            state_reg   <= S_WR_END;
            bus_reg     <= bus_for_state(S_WR_END, job_head);
            discard_reg <= flush_req;
          end
        end
        S_WR_END: begin
          state_reg <= S_WR_SOR;
          bus_reg   <= bus_for_state(S_WR_SOR, job_head);
        end
        S_WR_SOR: begin
          state_reg    <= S_POLL;
          poll_cnt_reg <= '0;
          bus_reg      <= bus_for_state(S_POLL, job_head);
        end
        S_POLL: begin
          if (!busy) begin
            state_reg <= S_RD_QUO;
            bus_reg   <= bus_for_state(S_RD_QUO, job_head);
          end else if (timeout_hit) begin
            state_reg <= S_SYNC;
            bus_reg   <= bus_for_state(S_SYNC, job_head);
          end else begin
            poll_cnt_reg <= poll_cnt_reg + 1'b1;
          end
        end
        S_RD_QUO: begin
          quo_reg   <= div.read_data;
          state_reg <= S_RD_REM;
          bus_reg   <= bus_for_state(S_RD_REM, job_head);
        end
        S_RD_REM: begin
          rem_reg   <= div.read_data;
          state_reg <= S_PUSH;
          bus_reg   <= bus_for_state(S_PUSH, job_head);
        end
        S_PUSH: begin
          // A flushed job's result is dropped here instead of pushed.
          if (discard_reg || !res_full) begin
            state_reg <= S_IDLE;
            bus_reg   <= bus_for_state(S_IDLE, job_head);
          end
        end
        default: begin
          state_reg <= S_SYNC;
          bus_reg   <= bus_for_state(S_SYNC, job_head);
        end
      endcase
      // A flush while a job is in flight marks its result for discard.
      if (flush_req && in_job) discard_reg <= 1'b1;
    end
  end

  assign div.address    = bus_reg.address;
  assign div.write_data = bus_reg.write_data;
  assign div.we         = bus_reg.we;
  assign div.re         = bus_reg.re;

  // Host read mux; reads have no side effects.
  always_comb begin
    host.read_data = '0;
    case (host.address)
      REG_STATUS: begin
        host.read_data[ST_ACTIVE]               = (state_reg != S_IDLE);
        host.read_data[ST_JOB_FULL]             = job_full;
        host.read_data[ST_RES_VALID]            = !res_empty;
        host.read_data[ST_JOB_OVF]              = job_ovf_reg;
        host.read_data[ST_TIMEOUT]              = timeout_reg;
        host.read_data[ST_JOB_CNT_LSB +: 4]     = 4'(job_count);
        host.read_data[ST_RES_CNT_LSB +: 4]     = 4'(res_count);
      end
      REG_JOB_END: host.read_data = end_stage_reg;
      REG_RES_QUO: host.read_data = res_empty ? 32'h0 : res_head[63:32];
      REG_RES_REM: host.read_data = res_empty ? 32'h0 : res_head[31:0];
      default: ;
    endcase
  end

  logic unused_re;
  assign unused_re = host.re;

endmodule

// File: doc/div_job_queue.md
Name: div_job_queue

Overview:
- Memory-mapped peripheral on the same 8-bit-offset register bus as seq_divider, sitting directly upstream and downstream of it.
- Host pushes dividend/divisor pairs into a job FIFO. A master-side FSM drives seq_divider through its register interface: write END, write SOR, poll INFO, read QUO and REM.
- Each quotient/remainder pair goes into a result FIFO that the host reads and pops, so the host no longer hand-sequences every division.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, 2..8.
- POLL_LIMIT, 48: maximum POLL cycles before a job is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- address  in  8  slave register offset
- write_data  in  32  slave write data
- read_data  out  32  slave read data, combinational from address
- we  in  1  slave write strobe
- re  in  1  slave read strobe; reads have no side effects
- div_address  out  8  offset driven to seq_divider
- div_write_data  out  32  data to seq_divider
- div_read_data  in  32  seq_divider read_data
- div_we  out  1  write strobe to seq_divider
- div_re  out  1  read strobe to seq_divider

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- On reset: both FIFOs empty, sticky flags 0, staged dividend 0, FSM in SYNC. div_we=0, div_re=1, div_address=0x00, div_write_data=0.
- Slave register map:
  - 0x00 STATUS (read-only): [0] engine active (FSM not IDLE), [1] job_full, [2] res_valid, [3] job_ovf (sticky), [4] timeout (sticky), [11:8] job count, [15:12] result count; other bits 0.
  - 0x04 JOB_END: write stages the dividend; read returns the staged value.
  - 0x08 JOB_SOR: write pushes {staged dividend, write_data}. If full, the push is dropped and job_ovf is set. Reads 0.
  - 0x0C RES_QUO / 0x10 RES_REM: head quotient / remainder; 0 when empty.
  - 0x14 RES_POP: any write pops the head; ignored when empty.
  - 0x18 CTRL: bit0=1 clears both sticky flags; bit1=1 flushes both FIFOs.
  - Unmapped offsets read 0 and ignore writes.
- Full/empty decisions use the registered counts. If a host push and an engine pop of the job FIFO coincide while full, the push is still dropped.
- Master-side rule: div_re=1 only in SYNC/POLL/RD_QUO/RD_REM; div_we=1 only in WR_END/WR_SOR.
- FSM states:
  - SYNC: address 0x00; wait until div_read_data[0]=0, then IDLE. Guards against a divider still busy after our reset.
  - IDLE: job FIFO non-empty -> WR_END.
  - WR_END: address 0x04, data = head dividend -> WR_SOR.
  - WR_SOR: address 0x08, data = head divisor; pop the job FIFO -> POLL, clear the poll counter.
  - POLL: address 0x00. busy=0 -> RD_QUO. Poll counter reaching POLL_LIMIT -> set timeout, drop the job, go to SYNC.
  - RD_QUO: address 0x0C; latch the quotient -> RD_REM.
  - RD_REM: address 0x10; latch the remainder -> PUSH.
  - PUSH: if the result FIFO is not full, push {quo, rem} and go to IDLE; otherwise stall in PUSH (the divider idles meanwhile).
- Timing: with WR_END at cycle w, busy is first seen low in POLL at w+34, PUSH occurs at w+37, and the result is visible on the slave side at w+38. Back-to-back jobs therefore complete every 39 cycles.
- Divide by zero needs no special handling: the divider returns quotient 0xFFFFFFFF and remainder = dividend.
- Flush mid-job: the FSM completes the divider transaction but discards that result (no PUSH). A host push in the same cycle as a flush is dropped.
- Reset mid-job: abandons everything; FSM restarts in SYNC.

Decomposition:
- Package div_q_pkg: seq_divider offsets (0x00/04/08/0C/10), this block's offsets (0x00–0x18), STATUS bit positions, FSM state encoding.
- Sub-module sync_fifo, parameterised WIDTH/DEPTH, with push/pop/flush, full/empty/count and head output. Instantiated twice at width 64.

Test Plan:
- Push 100/7 and pair with a real seq_divider -> RES_QUO=14, RES_REM=2, res_valid rises exactly at w+38; RES_POP -> res_valid=0.
- Push 5/0 -> quotient 0xFFFFFFFF, remainder 5; no flags set.
- Push 4 jobs (10/3, 20/6, 7/7, 0/9) then a fifth -> job_ovf=1, job count 4; results come out in order: 3r1, 3r2, 1r0, 0r0.
- Fill the result FIFO with 4 results and queue a fifth job -> FSM stalls in PUSH; one pop -> the fifth result is pushed the next cycle.
- Stub divider holding busy=1 -> timeout=1 after POLL_LIMIT cycles, job dropped, FSM in SYNC; CTRL bit0 write -> flags clear.
- Assert rst during POLL while the stub is still busy -> FSM waits in SYNC, with no div_we, until busy=0, then processes the next pushed job normally.
